elastic_operator: RTL and testbench

//  Dataflow operator node with N-input join, registered ALU op, DEPTH-entry result FIFO and M-output fork.

---
 rtl/elastic_operator_pkg.sv | 38 +++
 rtl/elastic_operator_fifo.sv | 66 ++++++
 rtl/elastic_operator.sv | 188 ++++++++++++++++++
 tb/tb_elastic_operator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_operator_pkg.sv
// Shared definitions for the elastic operator node: ALU op-codes and the
// elaboration-time mapping from the OP name string to an op-code.
package elastic_operator_pkg;

  // Width of the packed OP name parameter (up to 4 ASCII characters).
  localparam int OP_STR_W = 32;

  typedef enum logic [2:0] {
    OP_PASS,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_ADDI,
    OP_SUBI,
    OP_MULI
  } op_e;

  // Unknown names fall back to pass-through of operand 0.
  function automatic op_e op_decode(input logic [OP_STR_W-1:0] name);
    op_e code;
    code = OP_PASS;
    if (name == OP_STR_W'("add")) begin
      code = OP_ADD;
    end else if (name == OP_STR_W'("sub")) begin
      code = OP_SUB;
    end else if (name == OP_STR_W'("mul")) begin
      code = OP_MUL;
    end else if (name == OP_STR_W'("addi")) begin
      code = OP_ADDI;
    end else if (name == OP_STR_W'("subi")) begin
      code = OP_SUBI;
    end else if (name == OP_STR_W'("muli")) begin
      code = OP_MULI;
    end
    return code;
  endfunction

endpackage

// File: rtl/elastic_operator_fifo.sv
// Result FIFO for the elastic operator: circular storage with wrapping
// pointers, an occupancy counter and full/empty flags. The head is read
// combinationally; push and pop are single-cycle pulses.
module elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [OCC_W-1:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_reg == OCC_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign occupancy = count_reg;
  assign head      = mem[rd_ptr_reg];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/elastic_operator.sv
// Dataflow operator node: N-channel operand join, ALU whose result is
// registered into a result FIFO, and an M-branch fork where every branch
// takes the FIFO head independently. Req is a level, ack a one-cycle pulse,
// on both the upstream and downstream sides.
module elastic_operator
  import elastic_operator_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 2,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4,
  parameter logic [OP_STR_W-1:0]   OP          = OP_STR_W'("add"),
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0]        occupancy,
  output logic                              err
);

  localparam op_e OP_CODE = op_decode(OP);

  // Join state
  logic [DATA_WIDTH-1:0]  din_ch     [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_reg   [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  has_reg;
  logic [INPUT_SIZE-1:0]  has_next;
  logic [INPUT_SIZE-1:0]  req_l_reg;
  logic [INPUT_SIZE-1:0]  req_l_next;
  logic                   err_reg;
  logic                   err_next;
  logic                   fire;
  logic [DATA_WIDTH-1:0]  alu_result;

  // FIFO interface
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [DATA_WIDTH-1:0]  fifo_head;

  // Fork state
  logic [OUTPUT_SIZE-1:0] ack_r_reg;
  logic [OUTPUT_SIZE-1:0] new_ack;
  logic [OUTPUT_SIZE-1:0] served_reg;
  logic [OUTPUT_SIZE-1:0] served_next;
  logic [DATA_WIDTH-1:0]  dout_reg   [OUTPUT_SIZE];

  genvar gi;

  for (gi = 0; gi < INPUT_SIZE; gi++) begin : g_din
    assign din_ch[gi] = din[DATA_WIDTH*gi +: DATA_WIDTH];
  end

  for (gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_dout
    assign dout[DATA_WIDTH*gi +: DATA_WIDTH] = dout_reg[gi];
  end

  assign req_l = req_l_reg;
  assign ack_r = ack_r_reg;
  assign err   = err_reg;

  // Fire once every operand is held and the FIFO can take the result,
  // counting a head that leaves in this very cycle as free space.
  assign fire = (&has_reg) && (!fifo_full || fifo_pop);

  // Join next-state: request empty channels, capture on ack, flag acks to full channels.
  always_comb begin
    has_next   = has_reg;
    req_l_next = req_l_reg;
    err_next   = err_reg;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (fire) begin
        has_next[i] = 1'b0;
      end
      if (ack_l[i]) begin
        if (has_reg[i]) begin
          err_next = 1'b1;
        end else begin
          has_next[i]   = 1'b1;
          req_l_next[i] = 1'b0;
        end
      end else if (!has_reg[i] && !req_l_reg[i]) begin
        req_l_next[i] = 1'b1;
      end
    end
  end

  // Join registers; operands are sampled on the clock while ack_l is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      has_reg   <= '0;
      req_l_reg <= '0;
      err_reg   <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        opnd_reg[i] <= '0;
      end
    end else begin
      has_reg   <= has_next;
      req_l_reg <= req_l_next;
      err_reg   <= err_next;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (ack_l[i] && !has_reg[i]) begin
          opnd_reg[i] <= din_ch[i];
        end
      end
    end
  end

  // ALU: op fixed at elaboration; unsigned arithmetic truncated to DATA_WIDTH.
  always_comb begin
    alu_result = opnd_reg[0];
    case (OP_CODE)
      OP_ADD: begin
        for (int i = 1; i < INPUT_SIZE; i++) begin
          alu_result = alu_result + opnd_reg[i];
        end
      end
      OP_SUB: begin
        for (int i = 1; i < INPUT_SIZE; i++) begin
          alu_result = alu_result - opnd_reg[i];
        end
      end
      OP_MUL: begin
        for (int i = 1; i < INPUT_SIZE; i++) begin
          alu_result = alu_result * opnd_reg[i];
        end
      end
      OP_ADDI: alu_result = opnd_reg[0] + IMMEDIATE;
      OP_SUBI: alu_result = opnd_reg[0] - IMMEDIATE;
      OP_MULI: alu_result = opnd_reg[0] * IMMEDIATE;
      default: alu_result = opnd_reg[0];
    endcase
  end

  elastic_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (alu_result),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // Fork: a branch is acked when it requests, has not yet taken this head,
  // and was not acked last cycle (ack stays a single-cycle pulse).
  always_comb begin
    new_ack = '0;
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      new_ack[j] = !fifo_empty && req_r[j] && !served_reg[j] && !ack_r_reg[j];
    end
  end

  // The head leaves only when every branch has taken it.
  assign fifo_pop    = !fifo_empty && (&(served_reg | new_ack));
  assign served_next = fifo_pop ? '0 : (served_reg | new_ack);

  // Fork registers: ack pulse, per-branch result latch and served tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r_reg  <= '0;
      served_reg <= '0;
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        dout_reg[j] <= '0;
      end
    end else begin
      ack_r_reg  <= new_ack;
      served_reg <= served_next;
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        if (new_ack[j]) begin
          dout_reg[j] <= fifo_head;
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_operator.sv
// Scoreboard bench for elastic_operator: directed operand sets push their
// hand-computed results into per-branch queues; a monitor pops and compares
// on every ack_r pulse.
module tb_elastic_operator;

  logic        clk;
  logic        rst;

  // DUT A: 2-input add, 3 branches, DEPTH 4
  logic [1:0]  a_req_l;
  logic [1:0]  a_ack_l;
  logic [63:0] a_din;
  logic [2:0]  a_req_r;
  logic [2:0]  a_ack_r;
  logic [95:0] a_dout;
  logic [2:0]  a_occ;
  logic        a_err;

  // DUT B: 8-bit addi 2; DUT C: 8-bit subi 2
  logic [0:0]  b_req_l, b_ack_l, b_req_r, b_ack_r;
  logic [7:0]  b_din, b_dout;
  logic [1:0]  b_occ;
  logic        b_err;
  logic [0:0]  c_req_l, c_ack_l, c_req_r, c_ack_r;
  logic [7:0]  c_din, c_dout;
  logic [1:0]  c_occ;
  logic        c_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_sent  = 0;
  int          last_ack_cyc = 0;
  int          lat_ref = 0;
  bit          lat_armed = 1'b0;
  int          a_cnt [3];
  int          base_cnt [3];
  logic [2:0]  a_prev = '0;
  logic [31:0] sbq [5][$];

  elastic_operator #(
    .DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(3), .DEPTH(4),
    .OP("add"), .IMMEDIATE(32'd0)
  ) u_dut (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .occupancy(a_occ), .err(a_err)
  );

  elastic_operator #(
    .DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2),
    .OP("addi"), .IMMEDIATE(8'd2)
  ) u_dut_addi (
    .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .occupancy(b_occ), .err(b_err)
  );

  elastic_operator #(
    .DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2),
    .OP("subi"), .IMMEDIATE(8'd2)
  ) u_dut_subi (
    .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din),
    .req_r(c_req_r), .ack_r(c_ack_r), .dout(c_dout), .occupancy(c_occ), .err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic sb_check(input int br, input logic [31:0] got);
    logic [31:0] exp;
    n_tests++;
    if (sbq[br].size() == 0) begin
      n_fail++;
      $display("FAIL sb_br%0d: got %0d expected no output", br, got);
    end else begin
      exp = sbq[br].pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sb_br%0d: got %0d expected %0d", br, got, exp);
      end else begin
        $display("[TB] br%0d dout=%0d ok", br, got);
      end
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < 5; k++) s += sbq[k].size();
    return s;
  endfunction

  // Monitor: every ack_r pulse is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int j = 0; j < 3; j++) begin
          if (a_ack_r[j]) begin
            a_cnt[j]++;
            check($sformatf("ack_r_gap_br%0d", j), 32'(a_prev[j]), 32'd0);
            sb_check(j, a_dout[j*32 +: 32]);
          end
        end
        if (lat_armed && a_ack_r[0]) begin
          check("first_ack_latency", cyc - lat_ref, 32'd3);
          lat_armed = 1'b0;
        end
        if (b_ack_r[0]) sb_check(3, 32'(b_dout));
        if (c_ack_r[0]) sb_check(4, 32'(c_dout));
      end
      a_prev = a_ack_r;
    end
  end

  task automatic produce(input int ch, input logic [31:0] val, input int dly);
    int t;
    t = 0;
    while (a_req_l[ch] !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    if (a_req_l[ch] !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_l_timeout_ch%0d: got 0 expected 1 within 200 cycles", ch);
    end else begin
      repeat (dly) tick();
      a_din[ch*32 +: 32] = val;
      a_ack_l[ch] = 1'b1;
      if (cyc > last_ack_cyc) last_ack_cyc = cyc;
      tick();
      a_ack_l[ch] = 1'b0;
    end
  endtask

  task automatic send_set(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                          input int dly_a, input int dly_b);
    for (int j = 0; j < 3; j++) sbq[j].push_back(exp);
    n_sent++;
    fork
      produce(0, a, dly_a);
      produce(1, b, dly_b);
    join
  endtask

  task automatic produce_small(input int which, input logic [7:0] val);
    int t;
    t = 0;
    while (((which == 1) ? b_req_l[0] : c_req_l[0]) !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    if (((which == 1) ? b_req_l[0] : c_req_l[0]) !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_l_timeout_dut%0d: got 0 expected 1 within 200 cycles", which);
    end else begin
      if (which == 1) begin
        b_din = val; b_ack_l = 1'b1; tick(); b_ack_l = 1'b0;
      end else begin
        c_din = val; c_ack_l = 1'b1; tick(); c_ack_l = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (pending() != 0 && t < 300) begin
      tick();
      t++;
    end
    check("drain_pending", pending(), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_l"}, 32'(a_req_l), 32'd0);
    check({tag, "_ack_r"}, 32'(a_ack_r), 32'd0);
    for (int j = 0; j < 3; j++) check($sformatf("%s_dout%0d", tag, j), a_dout[j*32 +: 32], 32'd0);
    check({tag, "_occupancy"}, 32'(a_occ), 32'd0);
    check({tag, "_err"}, 32'(a_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_ack_l = '0; a_din = '0; a_req_r = '0;
    b_ack_l = '0; b_din = '0; b_req_r = 1'b1;
    c_ack_l = '0; c_din = '0; c_req_r = 1'b1;
    for (int j = 0; j < 3; j++) a_cnt[j] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then req_l rises in the 2nd cycle after deassertion
    check_reset_outputs("reset");
    tick();
    check("req_l_first_raise", 32'(a_req_l), 32'd3);

    // Test 1: streaming add with latency probe and a wrapping sum
    a_req_r = 3'b111;
    lat_armed = 1'b1;
    last_ack_cyc = 0;
    send_set(32'd0, 32'd10, 32'd10, 0, 2);
    lat_ref = last_ack_cyc;
    send_set(32'd1, 32'd11, 32'd12, 0, 0);
    send_set(32'd2, 32'd12, 32'd14, 1, 0);
    send_set(32'd3, 32'd13, 32'd16, 0, 0);
    send_set(32'hFFFF_FFFF, 32'd2, 32'd1, 0, 0);
    drain();
    check("occ_after_stream", 32'(a_occ), 32'd0);

    // Test 3: no consumer -> FIFO fills, 5th set held, req_l low
    a_req_r = 3'b000;
    send_set(32'd20, 32'd1, 32'd21, 0, 0);
    send_set(32'd30, 32'd2, 32'd32, 0, 0);
    send_set(32'd40, 32'd3, 32'd43, 0, 0);
    send_set(32'd50, 32'd4, 32'd54, 0, 0);
    send_set(32'd60, 32'd5, 32'd65, 0, 0);
    repeat (3) tick();
    check("occ_full", 32'(a_occ), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("req_l_backpressure", 32'(a_req_l), 32'd0);
      tick();
    end
    check("occ_full_held", 32'(a_occ), 32'd4);
    a_req_r = 3'b111;
    drain();
    check("occ_after_release", 32'(a_occ), 32'd0);

    // Test 4: branch 2 withholds req_r; branches 0,1 take the head once
    for (int j = 0; j < 3; j++) base_cnt[j] = a_cnt[j];
    a_req_r = 3'b011;
    send_set(32'd100, 32'd200, 32'd300, 0, 0);
    send_set(32'd7, 32'd8, 32'd15, 0, 0);
    send_set(32'd1000, 32'd1, 32'd1001, 0, 0);
    repeat (12) tick();
    check("br0_single_ack", a_cnt[0] - base_cnt[0], 32'd1);
    check("br1_single_ack", a_cnt[1] - base_cnt[1], 32'd1);
    check("br2_no_ack", a_cnt[2] - base_cnt[2], 32'd0);
    check("occ_stalled", 32'(a_occ), 32'd3);
    a_req_r = 3'b111;
    drain();
    for (int j = 0; j < 3; j++) check($sformatf("count_br%0d", j), a_cnt[j], n_sent);

    // Test 5: reset with occupancy 3 and has=01
    a_req_r = 3'b000;
    send_set(32'd1, 32'd1, 32'd2, 0, 0);
    send_set(32'd2, 32'd2, 32'd4, 0, 0);
    send_set(32'd3, 32'd3, 32'd6, 0, 0);
    produce(0, 32'd99, 0);
    repeat (2) tick();
    check("occ_before_rst", 32'(a_occ), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) sbq[k].delete();
    n_sent = 0;
    for (int j = 0; j < 3; j++) a_cnt[j] = 0;
    check_reset_outputs("midrst");
    tick();
    check("req_l_after_midrst", 32'(a_req_l), 32'd3);
    a_req_r = 3'b111;
    send_set(32'd5, 32'd7, 32'd12, 0, 0);
    drain();

    // Test 6: ack on a full channel sets sticky err, operand kept
    produce(0, 32'd50, 0);
    tick();
    a_din[31:0] = 32'd777;
    a_ack_l[0] = 1'b1;
    tick();
    a_ack_l[0] = 1'b0;
    check("err_set", 32'(a_err), 32'd1);
    for (int j = 0; j < 3; j++) sbq[j].push_back(32'd110);
    n_sent++;
    produce(1, 32'd60, 0);
    drain();
    repeat (5) tick();
    check("err_sticky", 32'(a_err), 32'd1);
    for (int j = 0; j < 3; j++) check($sformatf("count_final_br%0d", j), a_cnt[j], n_sent);

    // Test 2: 8-bit immediate ops with wrap
    sbq[3].push_back(32'd1);
    produce_small(1, 8'd255);
    sbq[4].push_back(32'd254);
    produce_small(2, 8'd0);
    sbq[3].push_back(32'd9);
    produce_small(1, 8'd7);
    sbq[4].push_back(32'd3);
    produce_small(2, 8'd5);
    drain();
    check("addi_err", 32'(b_err), 32'd0);
    check("subi_occ", 32'(c_occ), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
